// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
// The localparams describe the default configuration. The helper functions
// take their field widths as arguments, so a top built with other parameters
// can use them too. Fields of up to 64-bit PCs and 8-bit counters are
// supported.
package btb_pkg;

  localparam int unsigned BTB_XLEN     = 32;
  localparam int unsigned BTB_SETS     = 16;
  localparam int unsigned BTB_WAYS     = 2;
  localparam int unsigned BTB_CTR_BITS = 2;
  localparam int unsigned BTB_IDX_BITS = $clog2(BTB_SETS);
  localparam int unsigned BTB_TAG_BITS = BTB_XLEN - BTB_IDX_BITS - 2;

  // Weakly taken: MSB set, remaining bits clear.
  localparam logic [BTB_CTR_BITS-1:0] CTR_WEAK_TAKEN =
    BTB_CTR_BITS'(1) << (BTB_CTR_BITS - 1);

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [BTB_XLEN-1:0]     target;
    logic [BTB_CTR_BITS-1:0] ctr;
  } btb_entry_t;

  // Set index sits just above the ignored byte-offset bits pc[1:0].
  function automatic logic [63:0] idx_of(input logic [63:0] pc,
                                         input int unsigned idx_bits);
    return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] pc,
                                         input int unsigned idx_bits);
    return pc >> (idx_bits + 2);
  endfunction

  function automatic logic [7:0] weak_taken(input int unsigned ctr_bits);
    return 8'd1 << (ctr_bits - 1);
  endfunction

  // Saturating up/down counter step.
  function automatic logic [7:0] sat_update(input logic [7:0] ctr,
                                            input logic taken,
                                            input int unsigned ctr_bits);
    logic [7:0] max_val;
    max_val = 8'((9'd1 << ctr_bits) - 9'd1);
    if (taken) return (ctr == max_val) ? ctr : ctr + 8'd1;
    else       return (ctr == 8'd0)    ? ctr : ctr - 8'd1;
  endfunction

endpackage

// File: rtl/btb_way_select.sv
// Combinational tag compare across the ways of one set.
//   way_valid / way_tag : valid bits and tags of the indexed set
//   tag                 : tag to match
//   hit / hit_way       : a valid way holds the tag, and which one
//   any_invalid / first_invalid_way : lowest-numbered free way, if any
module btb_way_select
  import btb_pkg::*;
#(
  parameter int unsigned WAYS     = BTB_WAYS,
  parameter int unsigned TAG_BITS = BTB_TAG_BITS,
  parameter int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0]               way_valid,
  input  logic [WAYS-1:0][TAG_BITS-1:0] way_tag,
  input  logic [TAG_BITS-1:0]           tag,
  output logic                          hit,
  output logic [WAY_BITS-1:0]           hit_way,
  output logic [WAY_BITS-1:0]           first_invalid_way,
  output logic                          any_invalid
);

  always_comb begin
    hit               = 1'b0;
    hit_way           = '0;
    any_invalid       = 1'b0;
    first_invalid_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!way_valid[w] && !any_invalid) begin
        any_invalid       = 1'b1;
        first_invalid_way = WAY_BITS'(w);
      end
    end
  end

endmodule

// File: rtl/btb_set_assoc.sv
// N-way set-associative branch target buffer.
//   btb_clk, btb_reset (sync, active-high), btb_flush : clock / clear controls
//   btb_write, btb_branch_taken, btb_new_pc, btb_data : resolved-branch update
//   btb_pc                                            : fetch lookup address
//   btb_hit, btb_valid_prediction, btb_target         : combinational lookup result
module btb_set_assoc
  import btb_pkg::*;
#(
  parameter int unsigned XLEN     = BTB_XLEN,
  parameter int unsigned SETS     = BTB_SETS,
  parameter int unsigned WAYS     = BTB_WAYS,
  parameter int unsigned CTR_BITS = BTB_CTR_BITS
) (
  input  logic            btb_clk,
  input  logic            btb_reset,
  input  logic            btb_flush,
  input  logic            btb_write,
  input  logic            btb_branch_taken,
  input  logic [XLEN-1:0] btb_pc,
  input  logic [XLEN-1:0] btb_new_pc,
  input  logic [XLEN-1:0] btb_data,
  output logic            btb_hit,
  output logic            btb_valid_prediction,
  output logic [XLEN-1:0] btb_target
);

  localparam int unsigned IDX_BITS = $clog2(SETS);
  localparam int unsigned TAG_BITS = XLEN - IDX_BITS - 2;
  localparam int unsigned WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(weak_taken(CTR_BITS));

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  entry_t              mem [SETS][WAYS];
  logic [WAY_BITS-1:0] victim_ptr [SETS];

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;

  assign lk_idx = IDX_BITS'(idx_of(64'(btb_pc), IDX_BITS));
  assign lk_tag = TAG_BITS'(tag_of(64'(btb_pc), IDX_BITS));
  assign up_idx = IDX_BITS'(idx_of(64'(btb_new_pc), IDX_BITS));
  assign up_tag = TAG_BITS'(tag_of(64'(btb_new_pc), IDX_BITS));

  logic [WAYS-1:0]               lk_valid, up_valid;
  logic [WAYS-1:0][TAG_BITS-1:0] lk_tags, up_tags;

  always_comb begin
    lk_valid = '0;
    lk_tags  = '0;
    up_valid = '0;
    up_tags  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      lk_valid[w] = mem[lk_idx][w].valid;
      lk_tags[w]  = mem[lk_idx][w].tag;
      up_valid[w] = mem[up_idx][w].valid;
      up_tags[w]  = mem[up_idx][w].tag;
    end
  end

  logic                lk_hit, up_hit, up_any_invalid;
  logic [WAY_BITS-1:0] lk_hit_way, up_hit_way, up_first_invalid;
  logic [WAY_BITS-1:0] lk_unused_inv_way;
  logic                lk_unused_any_inv;

  btb_way_select #(.WAYS(WAYS), .TAG_BITS(TAG_BITS), .WAY_BITS(WAY_BITS)) u_lookup_sel (
    .way_valid         (lk_valid),
    .way_tag           (lk_tags),
    .tag               (lk_tag),
    .hit               (lk_hit),
    .hit_way           (lk_hit_way),
    .first_invalid_way (lk_unused_inv_way),
    .any_invalid       (lk_unused_any_inv)
  );

  btb_way_select #(.WAYS(WAYS), .TAG_BITS(TAG_BITS), .WAY_BITS(WAY_BITS)) u_update_sel (
    .way_valid         (up_valid),
    .way_tag           (up_tags),
    .tag               (up_tag),
    .hit               (up_hit),
    .hit_way           (up_hit_way),
    .first_invalid_way (up_first_invalid),
    .any_invalid       (up_any_invalid)
  );

  entry_t lk_entry, up_entry;
  logic [WAY_BITS-1:0] victim;

  always_comb begin
    lk_entry = mem[lk_idx][lk_hit_way];
    up_entry = mem[up_idx][up_hit_way];
    victim   = up_any_invalid ? up_first_invalid : victim_ptr[up_idx];
  end

  // Outputs are gated by the hit so uninitialised targets never leak out.
  assign btb_hit              = lk_hit;
  assign btb_valid_prediction = lk_hit & lk_entry.ctr[CTR_BITS-1];
  assign btb_target           = lk_hit ? lk_entry.target : '0;

  always_ff @(posedge btb_clk) begin
    if (btb_reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        victim_ptr[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          mem[s][w].valid <= 1'b0;
          mem[s][w].ctr   <= '0;
        end
      end
    end else if (btb_flush) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        victim_ptr[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          mem[s][w].valid <= 1'b0;
        end
      end
    end else if (btb_write) begin
      if (up_hit) begin
        mem[up_idx][up_hit_way].ctr <=
          CTR_BITS'(sat_update(8'(up_entry.ctr), btb_branch_taken, CTR_BITS));
        if (btb_branch_taken) begin
          mem[up_idx][up_hit_way].target <= btb_data;
        end
      end else if (btb_branch_taken) begin
        mem[up_idx][victim].valid  <= 1'b1;
        mem[up_idx][victim].tag    <= up_tag;
        mem[up_idx][victim].target <= btb_data;
        mem[up_idx][victim].ctr    <= CTR_WEAK;
        // Round-robin only advances when a valid entry is displaced.
        if (!up_any_invalid && (WAYS > 1)) begin
          victim_ptr[up_idx] <= victim_ptr[up_idx] + WAY_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_set_assoc.sv
module tb_btb_set_assoc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        wr = 1'b0;
  logic        taken = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] new_pc = '0;
  logic [31:0] data = '0;
  logic        hit;
  logic        pred;
  logic [31:0] target;

  int checks = 0;
  int errors = 0;

  btb_set_assoc dut (
    .btb_clk              (clk),
    .btb_reset            (rst),
    .btb_flush            (flush),
    .btb_write            (wr),
    .btb_branch_taken     (taken),
    .btb_pc               (pc),
    .btb_new_pc           (new_pc),
    .btb_data             (data),
    .btb_hit              (hit),
    .btb_valid_prediction (pred),
    .btb_target           (target)
  );

  always #5 clk = ~clk;

  // Reference model: 16 sets x 2 ways, counters 0..3, round-robin pointer.
  bit          m_valid [16][2];
  logic [31:0] m_pc    [16][2];   // full PC with low two bits dropped
  logic [31:0] m_tgt   [16][2];
  int          m_ctr   [16][2];
  int          m_ptr   [16];

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 2) % 16);
  endfunction

  function automatic logic [31:0] key_of(input logic [31:0] a);
    return a >> 2;   // two addresses alias iff they agree above bit 1
  endfunction

  task automatic model_lookup(input logic [31:0] a, output bit eh, output bit ep,
                              output logic [31:0] et);
    int s;
    s  = set_of(a);
    eh = 1'b0; ep = 1'b0; et = '0;
    for (int w = 0; w < 2; w++) begin
      if (m_valid[s][w] && m_pc[s][w] == key_of(a)) begin
        eh = 1'b1;
        ep = (m_ctr[s][w] >= 2);
        et = m_tgt[s][w];
      end
    end
  endtask

  task automatic model_clock(input bit r, input bit f, input bit w_en, input bit t,
                             input logic [31:0] npc, input logic [31:0] d);
    int s, hw, vw;
    if (r) begin
      for (int i = 0; i < 16; i++) begin
        m_ptr[i] = 0;
        for (int j = 0; j < 2; j++) begin m_valid[i][j] = 0; m_ctr[i][j] = 0; end
      end
    end else if (f) begin
      for (int i = 0; i < 16; i++) begin
        m_ptr[i] = 0;
        for (int j = 0; j < 2; j++) m_valid[i][j] = 0;
      end
    end else if (w_en) begin
      s  = set_of(npc);
      hw = -1;
      for (int j = 0; j < 2; j++)
        if (m_valid[s][j] && m_pc[s][j] == key_of(npc)) hw = j;
      if (hw >= 0) begin
        if (t) begin
          m_ctr[s][hw] = (m_ctr[s][hw] == 3) ? 3 : m_ctr[s][hw] + 1;
          m_tgt[s][hw] = d;
        end else begin
          m_ctr[s][hw] = (m_ctr[s][hw] == 0) ? 0 : m_ctr[s][hw] - 1;
        end
      end else if (t) begin
        vw = -1;
        for (int j = 0; j < 2; j++)
          if (!m_valid[s][j] && vw < 0) vw = j;
        if (vw < 0) begin
          vw       = m_ptr[s];
          m_ptr[s] = (m_ptr[s] + 1) % 2;
        end
        m_valid[s][vw] = 1;
        m_pc[s][vw]    = key_of(npc);
        m_tgt[s][vw]   = d;
        m_ctr[s][vw]   = 2;
      end
    end
  endtask

  task automatic check_lookup(input string name);
    bit eh, ep;
    logic [31:0] et;
    model_lookup(pc, eh, ep, et);
    checks++;
    assert (hit === eh) else begin
      errors++;
      $error("FAIL %s hit pc=%h got %0b want %0b", name, pc, hit, eh);
    end
    checks++;
    assert (pred === ep) else begin
      errors++;
      $error("FAIL %s pred pc=%h got %0b want %0b", name, pc, pred, ep);
    end
    checks++;
    assert (target === et) else begin
      errors++;
      $error("FAIL %s target pc=%h got %h want %h", name, pc, target, et);
    end
  endtask

  // One cycle: drive after the falling edge, check mid-cycle, clock, advance model.
  task automatic cyc(input bit r, input bit f, input bit w_en, input bit t,
                     input logic [31:0] npc, input logic [31:0] d,
                     input logic [31:0] lpc, input bit chk, input string name);
    rst = r; flush = f; wr = w_en; taken = t; new_pc = npc; data = d; pc = lpc;
    #1;
    if (chk) check_lookup(name);
    @(posedge clk);
    model_clock(r, f, w_en, t, npc, d);
    @(negedge clk);
  endtask

  task automatic look(input logic [31:0] lpc, input string name);
    cyc(0, 0, 0, 0, '0, '0, lpc, 1, name);
  endtask

  task automatic upd(input bit t, input logic [31:0] npc, input logic [31:0] d,
                     input logic [31:0] lpc, input string name);
    cyc(0, 0, 1, t, npc, d, lpc, 1, name);
  endtask

  task automatic check_forced_miss(input logic [31:0] a, input string name);
    pc = a;
    #1;
    checks++;
    assert (hit === 1'b0 && pred === 1'b0 && target === 32'h0) else begin
      errors++;
      $error("FAIL %s pc=%h got hit=%0b pred=%0b tgt=%h want 0/0/0", name, a, hit, pred, target);
    end
  endtask

  initial begin
    logic [31:0] rpc, rnpc;
    @(negedge clk);
    cyc(1, 0, 0, 0, '0, '0, '0, 0, "reset");
    cyc(1, 0, 0, 0, '0, '0, '0, 0, "reset");
    look(32'h100, "reset_miss");
    check_forced_miss(32'h100, "reset_zero");

    // Allocation is invisible in the write cycle, visible the next.
    upd(1, 32'h100, 32'h200, 32'h100, "alloc_same_cycle");
    look(32'h100, "alloc_hit");
    upd(0, 32'h100, '0, 32'h100, "nt1");
    upd(0, 32'h100, '0, 32'h100, "nt2");
    upd(0, 32'h100, '0, 32'h100, "nt3_floor");
    look(32'h100, "ctr_zero");
    for (int i = 0; i < 4; i++) upd(1, 32'h100, 32'h204 + i, 32'h100, "taken_up");
    look(32'h100, "ctr_sat");
    upd(0, 32'h100, '0, 32'h100, "sat_down1");
    look(32'h100, "sat_down1_chk");

    // Set 0 conflicts: 0x140 fills way 1, 0x180 and 0x1C0 evict round-robin.
    upd(1, 32'h140, 32'h1140, 32'h140, "fill_way1");
    upd(1, 32'h180, 32'h1180, 32'h100, "evict_way0");
    look(32'h100, "evicted_100");
    look(32'h140, "kept_140");
    look(32'h180, "new_180");
    upd(1, 32'h1C0, 32'h11C0, 32'h140, "evict_way1");
    look(32'h140, "evicted_140");
    look(32'h1C0, "new_1c0");
    look(32'h181, "low_bits_ignored");

    upd(1, 32'h300, 32'hABCD, 32'h300, "rbw_300");
    look(32'h300, "after_300");
    upd(0, 32'h500, 32'h5555, 32'h500, "nt_miss");
    look(32'h500, "nt_no_alloc");

    // Flush dominates a simultaneous write.
    for (int i = 0; i < 4; i++) upd(1, 32'h604 + 4 * i, 32'h7000 + i, '0, "populate");
    cyc(0, 1, 1, 1, 32'h400, 32'h4444, 32'h604, 1, "flush_cycle");
    for (int i = 0; i < 4; i++) look(32'h604 + 4 * i, "post_flush");
    look(32'h400, "flush_drop_write");
    check_forced_miss(32'h400, "flush_drop_write_zero");

    // Reset dominates a simultaneous write.
    for (int i = 0; i < 4; i++) upd(1, 32'h604 + 4 * i, 32'h7100 + i, '0, "repopulate");
    look(32'h608, "repop_hit");
    cyc(1, 0, 1, 1, 32'h400, 32'h4444, 32'h604, 0, "reset_cycle");
    for (int i = 0; i < 4; i++) look(32'h604 + 4 * i, "post_reset");
    look(32'h400, "reset_drop_write");
    check_forced_miss(32'h608, "reset_zero2");

    // Random traffic over a small address pool to force conflicts.
    for (int n = 0; n < 600; n++) begin
      rpc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      rnpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 59) == 0),
          $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
          rnpc, $urandom, rpc, 1, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
